// File: rtl/multicycle_cu_pkg.sv
// multicycle_cu_pkg: shared opcodes, ALU/PC/RegDst/Ext codes, FSM states and instruction classes
package multicycle_cu_pkg;
  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND = 6'b010000, OP_ANDI = 6'b010001, OP_OR = 6'b010010;
  localparam logic [5:0] OP_ORI = 6'b010011, OP_SLL = 6'b011000, OP_SLTI = 6'b011100;
  localparam logic [5:0] OP_SW = 6'b100110, OP_LW = 6'b100111;
  localparam logic [5:0] OP_BEQ = 6'b110000, OP_BNE = 6'b110001, OP_BLTZ = 6'b110010;
  localparam logic [5:0] OP_J = 6'b111000, OP_JAL = 6'b111001, OP_JR = 6'b111010, OP_HALT = 6'b111111;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR = 3'b011, ALU_AND = 3'b100, ALU_SLT = 3'b110;
  localparam logic [1:0] PC_NEXT_INS = 2'b00, PC_REL_JMP = 2'b01, PC_JR = 2'b10, PC_ABS_JMP = 2'b11;
  localparam logic [1:0] REG_31 = 2'b00, REG_RT = 2'b01, REG_RD = 2'b10;
  localparam logic EXT_ZERO = 1'b0, EXT_SIGN = 1'b1;
  localparam logic REG_FROM_ALU = 1'b0, REG_FROM_MEM = 1'b1;
  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_EXE_AL = 4'd2, S_EXE_BR = 4'd3, S_EXE_LS = 4'd4,
    S_MEM = 4'd5, S_WB_AL = 4'd6, S_WB_LD = 4'd7, S_HALT = 4'd8
  } state_t;
  typedef enum logic [3:0] {
    CL_ILL, CL_ALUR, CL_ALUI, CL_BR, CL_LD, CL_ST, CL_JMP, CL_LINK, CL_JR, CL_HALT
  } cls_t;
endpackage

// File: rtl/multicycle_cu_if.sv
// multicycle_cu_if: CU<->datapath bundle; in: Opcode/Funct/Zero/Sign/MemReady, out: enables, selects, ALUOp, State
interface multicycle_cu_if #(parameter int ALUOP_W = 3);
  logic [5:0] Opcode, Funct;
  logic Zero, Sign, MemReady;
  logic PCWre, IRWre, InsMemRW, RegWre, mRD, mWR;
  logic ALUSrcA, ALUSrcB, DBDataSrc, ExtSel, WrRegDSrc;
  logic [1:0] RegDst, PCSrc;
  logic [ALUOP_W-1:0] ALUOp;
  logic [3:0] State;
  modport master (
    input Opcode, Funct, Zero, Sign, MemReady,
    output PCWre, IRWre, InsMemRW, RegWre, mRD, mWR, ALUSrcA, ALUSrcB, DBDataSrc, ExtSel,
    output WrRegDSrc, RegDst, PCSrc, ALUOp, State
  );
  modport slave (
    output Opcode, Funct, Zero, Sign, MemReady,
    input PCWre, IRWre, InsMemRW, RegWre, mRD, mWR, ALUSrcA, ALUSrcB, DBDataSrc, ExtSel,
    input WrRegDSrc, RegDst, PCSrc, ALUOp, State
  );
endinterface

// File: rtl/cu_decode.sv
// cu_decode: opcode -> instruction class plus ALUOp/ALUSrcA/ALUSrcB/ExtSel; in: opcode, out: cls, aluOp, aluSrcA, aluSrcB, extSel
module cu_decode import multicycle_cu_pkg::*; #(
  parameter bit EN_LINK = 1'b1,
  parameter int ALUOP_W = 3
) (
  input  logic [5:0] opcode,
  output cls_t cls,
  output logic [ALUOP_W-1:0] aluOp,
  output logic aluSrcA,
  output logic aluSrcB,
  output logic extSel
);
  always_comb begin
    cls = CL_ILL;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL: cls = CL_ALUR;
      OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI: cls = CL_ALUI;
      OP_BEQ, OP_BNE, OP_BLTZ: cls = CL_BR;
      OP_LW: cls = CL_LD;
      OP_SW: cls = CL_ST;
      OP_J: cls = CL_JMP;
      OP_JAL: cls = EN_LINK ? CL_LINK : CL_ILL;
      OP_JR: cls = EN_LINK ? CL_JR : CL_ILL;
      OP_HALT: cls = CL_HALT;
      default: cls = CL_ILL;
    endcase
  end
  assign aluSrcA = opcode == OP_SLL;
  assign aluSrcB = cls inside {CL_ALUI, CL_LD, CL_ST};
  assign extSel = opcode inside {OP_ADDIU, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BLTZ} ? EXT_SIGN : EXT_ZERO;
  assign aluOp = ALUOP_W'(opcode inside {OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ} ? ALU_SUB :
                          opcode inside {OP_AND, OP_ANDI} ? ALU_AND :
                          opcode inside {OP_OR, OP_ORI} ? ALU_OR :
                          opcode == OP_SLL ? ALU_SLL :
                          opcode == OP_SLTI ? ALU_SLT : ALU_ADD);
endmodule

// File: rtl/multicycle_cu.sv
// multicycle_cu: IF/ID/EXE/MEM/WB sequencer; in: CLK, Reset (async, low), bus.Opcode/Zero/Sign/MemReady; out: bus enables, selects, ALUOp, State
module multicycle_cu import multicycle_cu_pkg::*; #(
  parameter bit EN_LINK = 1'b1,
  parameter bit MEM_WAIT = 1'b1,
  parameter int ALUOP_W = 3
) (
  input logic CLK,
  input logic Reset,
  multicycle_cu_if.master bus
);
  state_t state, nextState;
  cls_t cls;
  logic [ALUOP_W-1:0] aluOp;
  logic aluSrcA, aluSrcB, extSel, memDone, taken, selOn;
  logic pcWre, irWre, regWre, mRd, mWr, wrRegDSrc, dbDataSrc;
  logic [1:0] regDst, pcSrc;
  cu_decode #(.EN_LINK(EN_LINK), .ALUOP_W(ALUOP_W)) dec (
    .opcode(bus.Opcode), .cls(cls), .aluOp(aluOp), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .extSel(extSel)
  );
  assign memDone = !MEM_WAIT || bus.MemReady;
  // only branch opcodes reach EXE_BR, so anything not BEQ/BNE is BLTZ
  assign taken = bus.Opcode == OP_BEQ ? bus.Zero : bus.Opcode == OP_BNE ? !bus.Zero : bus.Sign;
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) state <= S_IF;
    else state <= nextState;
  always_comb begin
    nextState = state;
    pcWre = 1'b0;
    irWre = 1'b0;
    regWre = 1'b0;
    mRd = 1'b0;
    mWr = 1'b0;
    wrRegDSrc = 1'b0;
    dbDataSrc = REG_FROM_ALU;
    regDst = REG_31;
    pcSrc = PC_NEXT_INS;
    case (state)
      S_IF: begin
        irWre = 1'b1;
        nextState = S_ID;
      end
      S_ID:
        case (cls)
          CL_HALT: nextState = S_HALT;
          CL_BR: nextState = S_EXE_BR;
          CL_LD, CL_ST: nextState = S_EXE_LS;
          CL_ALUR, CL_ALUI: nextState = S_EXE_AL;
          default: begin
            nextState = S_IF;
            pcWre = 1'b1;
            pcSrc = cls == CL_JR ? PC_JR : cls inside {CL_JMP, CL_LINK} ? PC_ABS_JMP : PC_NEXT_INS;
            regWre = cls == CL_LINK;
          end
        endcase
      S_EXE_AL: nextState = S_WB_AL;
      S_WB_AL: begin
        regWre = 1'b1;
        wrRegDSrc = 1'b1;
        pcWre = 1'b1;
        regDst = cls == CL_ALUI ? REG_RT : REG_RD;
        nextState = S_IF;
      end
      S_EXE_BR: begin
        pcWre = 1'b1;
        pcSrc = taken ? PC_REL_JMP : PC_NEXT_INS;
        nextState = S_IF;
      end
      S_EXE_LS: nextState = S_MEM;
      S_MEM: begin
        mRd = cls == CL_LD;
        mWr = cls == CL_ST;
        if (memDone) begin
          nextState = cls == CL_LD ? S_WB_LD : S_IF;
          pcWre = cls != CL_LD;
        end
      end
      S_WB_LD: begin
        regWre = 1'b1;
        wrRegDSrc = 1'b1;
        dbDataSrc = REG_FROM_MEM;
        regDst = REG_RT;
        pcWre = 1'b1;
        nextState = S_IF;
      end
      S_HALT: nextState = S_HALT;
      default: nextState = S_IF;
    endcase
  end
  // the state register alone would show IF outputs during reset, so every output is gated by Reset
  assign selOn = Reset && state != S_IF;
  assign bus.PCWre = Reset && pcWre;
  assign bus.IRWre = Reset && irWre;
  assign bus.InsMemRW = Reset && irWre;
  assign bus.RegWre = Reset && regWre;
  assign bus.mRD = Reset && mRd;
  assign bus.mWR = Reset && mWr;
  assign bus.WrRegDSrc = Reset && wrRegDSrc;
  assign bus.DBDataSrc = Reset && dbDataSrc;
  assign bus.RegDst = Reset ? regDst : 2'b00;
  assign bus.PCSrc = Reset ? pcSrc : 2'b00;
  assign bus.ALUSrcA = selOn && aluSrcA;
  assign bus.ALUSrcB = selOn && aluSrcB;
  assign bus.ExtSel = selOn && extSel;
  assign bus.ALUOp = selOn ? aluOp : '0;
  assign bus.State = state;
endmodule

// File: tb/tb_multicycle_cu.sv
// tb_multicycle_cu: randomized per-cycle checking of multicycle_cu against an instruction-phase reference model
module tb_multicycle_cu;
  import multicycle_cu_pkg::*;
  localparam int K_NOP = 0, K_J = 1, K_JAL = 2, K_JR = 3, K_HALT = 4, K_BR = 5;
  localparam int K_LW = 6, K_SW = 7, K_ALUR = 8, K_ALUI = 9;
  typedef struct packed {
    logic [3:0] st;
    logic [5:0] ctl;
    logic [1:0] pcSrc;
    logic [1:0] regDst;
    logic wrSrc;
    logic dbSrc;
    logic ready;
  } ph_t;
  logic CLK = 1'b0, Reset = 1'b1, useB = 1'b0;
  logic [5:0] opcode = OP_SLTI, funct = 6'd0;
  logic zero = 1'b0, sign = 1'b0, memReady = 1'b0;
  int checks = 0, failures = 0;
  always #5 CLK = ~CLK;
  multicycle_cu_if #(.ALUOP_W(3)) busA ();
  multicycle_cu_if #(.ALUOP_W(3)) busB ();
  multicycle_cu #(.EN_LINK(1'b1), .MEM_WAIT(1'b1), .ALUOP_W(3)) dutA (.CLK(CLK), .Reset(Reset), .bus(busA));
  multicycle_cu #(.EN_LINK(1'b0), .MEM_WAIT(1'b0), .ALUOP_W(3)) dutB (.CLK(CLK), .Reset(Reset), .bus(busB));
  assign busA.Opcode = opcode;
  assign busA.Funct = funct;
  assign busA.Zero = zero;
  assign busA.Sign = sign;
  assign busA.MemReady = memReady;
  assign busB.Opcode = opcode;
  assign busB.Funct = funct;
  assign busB.Zero = zero;
  assign busB.Sign = sign;
  assign busB.MemReady = memReady;
  logic [17:0] allA, allB;
  logic [3:0] st;
  logic [5:0] ctl, sel;
  logic [1:0] pcSrc, regDst;
  logic wrSrc, dbSrc;
  assign allA = {busA.PCWre, busA.IRWre, busA.InsMemRW, busA.RegWre, busA.mRD, busA.mWR, busA.ALUSrcA,
                 busA.ALUSrcB, busA.DBDataSrc, busA.ExtSel, busA.WrRegDSrc, busA.RegDst, busA.PCSrc, busA.ALUOp};
  assign allB = {busB.PCWre, busB.IRWre, busB.InsMemRW, busB.RegWre, busB.mRD, busB.mWR, busB.ALUSrcA,
                 busB.ALUSrcB, busB.DBDataSrc, busB.ExtSel, busB.WrRegDSrc, busB.RegDst, busB.PCSrc, busB.ALUOp};
  assign st = useB ? busB.State : busA.State;
  assign ctl = useB ? {busB.PCWre, busB.IRWre, busB.InsMemRW, busB.RegWre, busB.mRD, busB.mWR}
                    : {busA.PCWre, busA.IRWre, busA.InsMemRW, busA.RegWre, busA.mRD, busA.mWR};
  assign pcSrc = useB ? busB.PCSrc : busA.PCSrc;
  assign regDst = useB ? busB.RegDst : busA.RegDst;
  assign wrSrc = useB ? busB.WrRegDSrc : busA.WrRegDSrc;
  assign dbSrc = useB ? busB.DBDataSrc : busA.DBDataSrc;
  assign sel = useB ? {busB.ALUOp, busB.ALUSrcA, busB.ALUSrcB, busB.ExtSel}
                    : {busA.ALUOp, busA.ALUSrcA, busA.ALUSrcB, busA.ExtSel};

  function automatic int kindOf(input logic [5:0] op, input bit link);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL: return K_ALUR;
      OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI: return K_ALUI;
      OP_BEQ, OP_BNE, OP_BLTZ: return K_BR;
      OP_LW: return K_LW;
      OP_SW: return K_SW;
      OP_J: return K_J;
      OP_JAL: return link ? K_JAL : K_NOP;
      OP_JR: return link ? K_JR : K_NOP;
      OP_HALT: return K_HALT;
      default: return K_NOP;
    endcase
  endfunction

  // single-cycle decode table: {ALUOp, ALUSrcA, ALUSrcB, ExtSel}
  function automatic logic [5:0] refSel(input logic [5:0] op);
    case (op)
      OP_ADD: return {ALU_ADD, 3'b000};
      OP_SUB: return {ALU_SUB, 3'b000};
      OP_AND: return {ALU_AND, 3'b000};
      OP_OR: return {ALU_OR, 3'b000};
      OP_SLL: return {ALU_SLL, 3'b100};
      OP_ADDIU: return {ALU_ADD, 3'b011};
      OP_ANDI: return {ALU_AND, 3'b010};
      OP_ORI: return {ALU_OR, 3'b010};
      OP_SLTI: return {ALU_SLT, 3'b011};
      OP_LW, OP_SW: return {ALU_ADD, 3'b011};
      OP_BEQ, OP_BNE, OP_BLTZ: return {ALU_SUB, 3'b001};
      default: return 6'b000000;
    endcase
  endfunction

  task automatic runInstr(input logic [5:0] op, input bit z, input bit s, input int waits);
    ph_t q[$];
    ph_t p;
    int k;
    bit mw, taken;
    k = kindOf(op, !useB);
    mw = !useB;
    taken = (op == OP_BEQ && z) || (op == OP_BNE && !z) || (op == OP_BLTZ && s);
    p = '0; p.st = S_IF; p.ctl = 6'b011000; q.push_back(p);
    p = '0; p.st = S_ID;
    case (k)
      K_J: begin p.ctl = 6'b100000; p.pcSrc = PC_ABS_JMP; end
      K_JAL: begin p.ctl = 6'b100100; p.pcSrc = PC_ABS_JMP; p.regDst = REG_31; p.wrSrc = 1'b0; end
      K_JR: begin p.ctl = 6'b100000; p.pcSrc = PC_JR; end
      K_NOP: begin p.ctl = 6'b100000; p.pcSrc = PC_NEXT_INS; end
      default: p.ctl = 6'b000000;
    endcase
    q.push_back(p);
    case (k)
      K_ALUR, K_ALUI: begin
        p = '0; p.st = S_EXE_AL; q.push_back(p);
        p.st = S_WB_AL; p.ctl = 6'b100100; p.regDst = k == K_ALUI ? REG_RT : REG_RD;
        p.wrSrc = 1'b1; p.dbSrc = REG_FROM_ALU; q.push_back(p);
      end
      K_BR: begin
        p = '0; p.st = S_EXE_BR; p.ctl = 6'b100000; p.pcSrc = taken ? PC_REL_JMP : PC_NEXT_INS; q.push_back(p);
      end
      K_LW, K_SW: begin
        p = '0; p.st = S_EXE_LS; q.push_back(p);
        p.st = S_MEM; p.ctl = k == K_LW ? 6'b000010 : 6'b000001; p.ready = 1'b0;
        for (int i = 0; i < (mw ? waits : 0); i++) q.push_back(p);
        p.ready = mw ? 1'b1 : 1'($urandom);
        p.ctl = k == K_LW ? 6'b000010 : 6'b100001; q.push_back(p);
        if (k == K_LW) begin
          p = '0; p.st = S_WB_LD; p.ctl = 6'b100100; p.regDst = REG_RT; p.dbSrc = REG_FROM_MEM; q.push_back(p);
        end
      end
      K_HALT: begin
        p = '0; p.st = S_HALT;
        for (int i = 0; i < 20; i++) q.push_back(p);
      end
      default: ;
    endcase
    foreach (q[i]) begin
      @(negedge CLK);
      if (i == 0) opcode = op;
      memReady = q[i].st == S_MEM ? q[i].ready : 1'($urandom);
      zero = q[i].st == S_EXE_BR ? z : 1'($urandom);
      sign = q[i].st == S_EXE_BR ? s : 1'($urandom);
      #1;
      checks++;
      if (st !== q[i].st) begin
        failures++;
        $display("FAIL state op=%b cyc=%0d got=%0d exp=%0d", op, i, st, q[i].st);
      end
      checks++;
      if (ctl !== q[i].ctl) begin
        failures++;
        $display("FAIL enables op=%b cyc=%0d got=%b exp=%b", op, i, ctl, q[i].ctl);
      end
      if (q[i].ctl[5]) begin
        checks++;
        if (pcSrc !== q[i].pcSrc) begin
          failures++;
          $display("FAIL pcsrc op=%b cyc=%0d got=%b exp=%b", op, i, pcSrc, q[i].pcSrc);
        end
      end
      if (q[i].ctl[2]) begin
        checks++;
        if ({regDst, dbSrc} !== {q[i].regDst, q[i].dbSrc}) begin
          failures++;
          $display("FAIL regdst_db op=%b cyc=%0d got=%b exp=%b", op, i, {regDst, dbSrc}, {q[i].regDst, q[i].dbSrc});
        end
      end
      if (q[i].ctl[2] && q[i].st != S_WB_LD) begin
        checks++;
        if (wrSrc !== q[i].wrSrc) begin
          failures++;
          $display("FAIL wrregdsrc op=%b cyc=%0d got=%b exp=%b", op, i, wrSrc, q[i].wrSrc);
        end
      end
      if (q[i].st != S_IF) begin
        checks++;
        if (sel !== refSel(op)) begin
          failures++;
          $display("FAIL selects op=%b cyc=%0d got=%b exp=%b", op, i, sel, refSel(op));
        end
      end
    end
  endtask

  task automatic test_reset;
    @(posedge CLK);
    #2 opcode = OP_SLTI;
    Reset = 1'b0;
    #1;
    checks++;
    if (busA.State !== 4'(S_IF) || busB.State !== 4'(S_IF)) begin
      failures++;
      $display("FAIL reset_state got=%0d/%0d exp=%0d", busA.State, busB.State, S_IF);
    end
    checks++;
    if (allA !== 18'd0) begin
      failures++;
      $display("FAIL reset_outputs_a got=%b exp=0", allA);
    end
    checks++;
    if (allB !== 18'd0) begin
      failures++;
      $display("FAIL reset_outputs_b got=%b exp=0", allB);
    end
    repeat (2) @(posedge CLK);
    #1 Reset = 1'b1;
  endtask

  task automatic test_add;
    useB = 1'b0;
    runInstr(OP_ADD, 1'b0, 1'b0, 0);
  endtask

  task automatic test_lw_wait;
    runInstr(OP_LW, 1'b0, 1'b0, 3);
    runInstr(OP_SW, 1'b0, 1'b0, 2);
  endtask

  task automatic test_branches;
    runInstr(OP_BEQ, 1'b1, 1'b0, 0);
    runInstr(OP_BNE, 1'b1, 1'b0, 0);
    runInstr(OP_BLTZ, 1'b0, 1'b1, 0);
    runInstr(OP_BEQ, 1'b0, 1'b1, 0);
    runInstr(OP_BLTZ, 1'b1, 1'b0, 0);
  endtask

  task automatic test_jumps;
    runInstr(OP_JAL, 1'b0, 1'b0, 0);
    runInstr(OP_JR, 1'b0, 1'b0, 0);
    runInstr(OP_J, 1'b0, 1'b0, 0);
    runInstr(6'b101010, 1'b0, 1'b0, 0);
  endtask

  task automatic test_halt;
    runInstr(OP_HALT, 1'b0, 1'b0, 0);
    test_reset;
    runInstr(OP_ORI, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_mid_sw;
    useB = 1'b0;
    @(negedge CLK);
    opcode = OP_SW;
    memReady = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    checks++;
    if ({busA.State, busA.mWR} !== {4'(S_MEM), 1'b1}) begin
      failures++;
      $display("FAIL sw_wait got=%0d/%b exp=%0d/1", busA.State, busA.mWR, S_MEM);
    end
    Reset = 1'b0;
    #1;
    checks++;
    if (busA.mWR !== 1'b0) begin
      failures++;
      $display("FAIL abort_mwr got=%b exp=0", busA.mWR);
    end
    checks++;
    if (busA.State !== 4'(S_IF)) begin
      failures++;
      $display("FAIL abort_state got=%0d exp=%0d", busA.State, S_IF);
    end
    @(posedge CLK);
    #1 Reset = 1'b1;
    runInstr(OP_ADDIU, 1'b0, 1'b0, 0);
  endtask

  task automatic test_link_disabled;
    test_reset;
    useB = 1'b1;
    runInstr(OP_JAL, 1'b0, 1'b0, 0);
    runInstr(OP_JR, 1'b0, 1'b0, 0);
    runInstr(OP_SW, 1'b0, 1'b0, 3);
    runInstr(OP_LW, 1'b0, 1'b0, 3);
  endtask

  task automatic test_random;
    logic [5:0] ops[$] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI,
                           OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_BLTZ, OP_J, OP_JAL, OP_JR};
    logic [5:0] op;
    for (int d = 0; d < 2; d++) begin
      test_reset;
      useB = d[0];
      for (int n = 0; n < 40; n++) begin
        op = $urandom_range(0, 20) < 17 ? ops[$urandom_range(0, 16)] : 6'($urandom);
        if (op == OP_HALT) op = OP_J;
        runInstr(op, 1'($urandom), 1'($urandom), $urandom_range(0, 3));
      end
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_lw_wait;
    test_branches;
    test_jumps;
    test_halt;
    test_reset_mid_sw;
    test_link_disabled;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
